// File: rtl/ovs_pkg.sv
// Shared sizing constants for the oversample filter.
package ovs_pkg;

    localparam int unsigned W_DATA_DEF = 18;
    localparam int unsigned N_CHAN_DEF = 8;
    localparam int unsigned W_CHAN_DEF = 3;
    localparam int unsigned W_OS_DEF   = 3;

    // Largest exponent the os field can encode, and the matching accumulator width
    localparam int unsigned K_MAX = (1 << W_OS_DEF) - 1;
    localparam int unsigned W_ACC = W_DATA_DEF + K_MAX;

    function automatic int unsigned acc_width(input int unsigned w_data, input int unsigned w_os);
        return w_data + (1 << w_os) - 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned w_os);
        return (1 << w_os) - 1;
    endfunction

endpackage

// File: rtl/ovs_acc_bank.sv
// Per-channel accumulator/counter storage; combinational read, one write per cycle.
module ovs_acc_bank #(
    parameter int unsigned N_CHAN = 8,
    parameter int unsigned W_CHAN = 3,
    parameter int unsigned ACC_W  = 25,
    parameter int unsigned CNT_W  = 7
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    clr_all,
    input  logic                    wr_en,
    input  logic [W_CHAN-1:0]       wr_chan,
    input  logic signed [ACC_W-1:0] wr_acc,
    input  logic [CNT_W-1:0]        wr_cnt,
    input  logic [W_CHAN-1:0]       rd_chan,
    output logic signed [ACC_W-1:0] rd_acc_c,
    output logic [CNT_W-1:0]        rd_cnt_c
);

    logic signed [ACC_W-1:0] acc_q [N_CHAN];
    logic [CNT_W-1:0]        cnt_q [N_CHAN];

    always_comb begin
        rd_acc_c = '0;
        rd_cnt_c = '0;
        if (32'(rd_chan) < N_CHAN) begin
            rd_acc_c = acc_q[rd_chan];
            rd_cnt_c = cnt_q[rd_chan];
        end
    end

    // Bulk clear wins over a channel write
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int unsigned i = 0; i < N_CHAN; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else if (clr_all) begin
            for (int unsigned i = 0; i < N_CHAN; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else if (wr_en) begin
            acc_q[wr_chan] <= wr_acc;
            cnt_q[wr_chan] <= wr_cnt;
        end
    end

endmodule

// File: rtl/oversample_filter.sv
// Multi-channel 2^k boxcar oversampling decimator with one-cycle output latency.
// Optional OVS_ROUND_EN: round-half-up with positive saturation instead of floor.
module oversample_filter
    import ovs_pkg::*;
#(
    parameter int unsigned W_DATA = W_DATA_DEF,
    parameter int unsigned N_CHAN = N_CHAN_DEF,
    parameter int unsigned W_CHAN = W_CHAN_DEF,
    parameter int unsigned W_OS   = W_OS_DEF
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     dv_in,
    input  logic [W_CHAN-1:0]        chan_in,
    input  logic signed [W_DATA-1:0] data_in,
    input  logic [W_OS-1:0]          os_in,
    input  logic                     os_update_in,
    output logic                     dv_out,
    output logic [W_CHAN-1:0]        chan_out,
    output logic signed [W_DATA-1:0] data_out,
    output logic [W_OS-1:0]          os_out
);

    localparam int unsigned ACC_W = acc_width(W_DATA, W_OS);
    localparam int unsigned CNT_W = cnt_width(W_OS);

    logic signed [ACC_W-1:0]  rd_acc_c;
    logic [CNT_W-1:0]         rd_cnt_c;
    logic                     valid_c;
    logic                     last_c;
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  wr_acc_c;
    logic [CNT_W-1:0]         wr_cnt_c;
    logic signed [W_DATA-1:0] res_c;

    ovs_acc_bank #(
        .N_CHAN (N_CHAN),
        .W_CHAN (W_CHAN),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) u_bank (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clr_all  (os_update_in),
        .wr_en    (valid_c),
        .wr_chan  (chan_in),
        .wr_acc   (wr_acc_c),
        .wr_cnt   (wr_cnt_c),
        .rd_chan  (chan_in),
        .rd_acc_c (rd_acc_c),
        .rd_cnt_c (rd_cnt_c)
    );

    // Sample accepted only for a real channel and outside an exponent reload
    always_comb begin
        valid_c  = dv_in && !os_update_in && (32'(chan_in) < N_CHAN);
        sum_c    = rd_acc_c + ACC_W'(data_in);
        last_c   = (rd_cnt_c == CNT_W'((32'd1 << os_out) - 32'd1));
        wr_acc_c = last_c ? '0 : sum_c;
        wr_cnt_c = last_c ? '0 : CNT_W'(rd_cnt_c + CNT_W'(1));
    end

`ifdef OVS_ROUND_EN
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'd1 << (W_DATA - 1)) - 64'd1);

    logic signed [ACC_W:0] rnd_c;
    logic signed [ACC_W:0] shf_c;

    // Bias of half an LSB is zero when k = 0, so pass-through stays exact
    always_comb begin
        rnd_c = (ACC_W+1)'(sum_c) + (ACC_W+1)'((33'd1 << os_out) >> 1);
        shf_c = rnd_c >>> os_out;
        res_c = (shf_c > SAT_MAX) ? W_DATA'(SAT_MAX) : W_DATA'(shf_c);
    end
`else
    always_comb begin
        res_c = W_DATA'(sum_c >>> os_out);
    end
`endif

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            dv_out   <= 1'b0;
            chan_out <= '0;
            data_out <= '0;
            os_out   <= '0;
        end else begin
            dv_out <= valid_c && last_c;
            if (valid_c && last_c) begin
                chan_out <= chan_in;
                data_out <= res_c;
            end
            if (os_update_in) begin
                os_out <= os_in;
            end
        end
    end

endmodule

// File: tb/tb_oversample_filter.sv
// Directed bench for oversample_filter; expectations switch on OVS_ROUND_EN.
module tb_oversample_filter;

    localparam int unsigned W_DATA = 18;
    localparam int unsigned N_CHAN = 6;
    localparam int unsigned W_CHAN = 3;
    localparam int unsigned W_OS   = 3;

    logic                     clk_in = 1'b0;
    logic                     reset_in;
    logic                     dv_in;
    logic [W_CHAN-1:0]        chan_in;
    logic signed [W_DATA-1:0] data_in;
    logic [W_OS-1:0]          os_in;
    logic                     os_update_in;
    logic                     dv_out;
    logic [W_CHAN-1:0]        chan_out;
    logic signed [W_DATA-1:0] data_out;
    logic [W_OS-1:0]          os_out;

    int n_cmp = 0;
    int n_err = 0;

    oversample_filter #(
        .W_DATA (W_DATA),
        .N_CHAN (N_CHAN),
        .W_CHAN (W_CHAN),
        .W_OS   (W_OS)
    ) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .dv_in        (dv_in),
        .chan_in      (chan_in),
        .data_in      (data_in),
        .os_in        (os_in),
        .os_update_in (os_update_in),
        .dv_out       (dv_out),
        .chan_out     (chan_out),
        .data_out     (data_out),
        .os_out       (os_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one cycle of inputs; returns at the following negedge
    task automatic drive(input logic dv, input logic [W_CHAN-1:0] ch, input int d);
        dv_in   = dv;
        chan_in = ch;
        data_in = W_DATA'(d);
        @(negedge clk_in);
        dv_in = 1'b0;
    endtask

    task automatic set_os(input logic [W_OS-1:0] k, input logic dv, input logic [W_CHAN-1:0] ch, input int d);
        os_in        = k;
        os_update_in = 1'b1;
        dv_in        = dv;
        chan_in      = ch;
        data_in      = W_DATA'(d);
        @(negedge clk_in);
        os_update_in = 1'b0;
        dv_in        = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic dv, input logic [W_CHAN-1:0] ch, input int d);
        check({tag, ".dv"}, 32'(dv_out), 32'(dv));
        if (dv) begin
            check({tag, ".chan"}, 32'(chan_out), 32'(ch));
            check({tag, ".data"}, 32'(data_out), 32'(d));
        end
    endtask

    initial begin
        reset_in     = 1'b1;
        dv_in        = 1'b0;
        chan_in      = '0;
        data_in      = '0;
        os_in        = '0;
        os_update_in = 1'b0;
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;

        check("rst.dv", 32'(dv_out), 32'd0);
        check("rst.chan", 32'(chan_out), 32'd0);
        check("rst.data", 32'(data_out), 32'd0);
        check("rst.os", 32'(os_out), 32'd0);

        // k=0 pass-through, including a negative sample
        drive(1'b1, 3'd3, 32'h1FFFF);
        check_out("k0.pos", 1'b1, 3'd3, 32'h1FFFF);
        drive(1'b0, 3'd0, 0);
        check_out("k0.idle", 1'b0, 3'd0, 0);
        check("k0.hold", 32'(data_out), 32'h1FFFF);
        drive(1'b1, 3'd5, -5);
        check_out("k0.neg", 1'b1, 3'd5, -5);

        // k=2, same channel back-to-back: sum 47
        set_os(3'd2, 1'b0, 3'd0, 0);
        check("k2.os", 32'(os_out), 32'd2);
        drive(1'b1, 3'd1, 10);
        check_out("k2.s1", 1'b0, 3'd1, 0);
        drive(1'b1, 3'd1, 11);
        check_out("k2.s2", 1'b0, 3'd1, 0);
        drive(1'b1, 3'd1, 12);
        check_out("k2.s3", 1'b0, 3'd1, 0);
        drive(1'b1, 3'd1, 14);
`ifdef OVS_ROUND_EN
        check_out("k2.avg", 1'b1, 3'd1, 12);
`else
        check_out("k2.avg", 1'b1, 3'd1, 11);
`endif

        // k=1, interleaved channels 0 and 4: each sums to -201
        set_os(3'd1, 1'b0, 3'd0, 0);
        drive(1'b1, 3'd0, -100);
        check_out("k1.a", 1'b0, 3'd0, 0);
        drive(1'b1, 3'd4, -100);
        check_out("k1.b", 1'b0, 3'd0, 0);
        drive(1'b1, 3'd0, -101);
`ifdef OVS_ROUND_EN
        check_out("k1.ch0", 1'b1, 3'd0, -100);
`else
        check_out("k1.ch0", 1'b1, 3'd0, -101);
`endif
        drive(1'b1, 3'd4, -101);
`ifdef OVS_ROUND_EN
        check_out("k1.ch4", 1'b1, 3'd4, -100);
`else
        check_out("k1.ch4", 1'b1, 3'd4, -101);
`endif

        // Out-of-range channel is ignored; channel 0 then averages 4 and 6
        drive(1'b1, 3'd7, 1000);
        check_out("oor.ign", 1'b0, 3'd0, 0);
        drive(1'b1, 3'd0, 4);
        check_out("oor.s1", 1'b0, 3'd0, 0);
        drive(1'b1, 3'd0, 6);
        check_out("oor.avg", 1'b1, 3'd0, 5);

        // k=3 full-scale: must not wrap negative
        set_os(3'd3, 1'b0, 3'd0, 0);
        for (int i = 0; i < 7; i++) drive(1'b1, 3'd2, 32'h1FFFF);
        check_out("k3.pre", 1'b0, 3'd2, 0);
        drive(1'b1, 3'd2, 32'h1FFFF);
        check_out("k3.full", 1'b1, 3'd2, 32'h1FFFF);

        // Exponent reload mid-average clears state and drops the coincident sample
        set_os(3'd2, 1'b0, 3'd0, 0);
        drive(1'b1, 3'd5, 100);
        drive(1'b1, 3'd5, 200);
        set_os(3'd1, 1'b1, 3'd5, 999);
        check("upd.os", 32'(os_out), 32'd1);
        check_out("upd.drop", 1'b0, 3'd5, 0);
        drive(1'b1, 3'd5, 7);
        check_out("upd.s1", 1'b0, 3'd5, 0);
        drive(1'b1, 3'd5, 8);
`ifdef OVS_ROUND_EN
        check_out("upd.avg", 1'b1, 3'd5, 8);
`else
        check_out("upd.avg", 1'b1, 3'd5, 7);
`endif

        // Reset mid-average: outputs and exponent cleared, partial sum discarded
        set_os(3'd2, 1'b0, 3'd0, 0);
        drive(1'b1, 3'd2, 1);
        drive(1'b1, 3'd2, 2);
        drive(1'b1, 3'd2, 3);
        reset_in = 1'b1;
        #2;
        check("mrst.dv", 32'(dv_out), 32'd0);
        check("mrst.chan", 32'(chan_out), 32'd0);
        check("mrst.data", 32'(data_out), 32'd0);
        check("mrst.os", 32'(os_out), 32'd0);
        reset_in = 1'b0;
        @(negedge clk_in);
        drive(1'b1, 3'd2, 40);
        check_out("mrst.first", 1'b1, 3'd2, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
